// File: rtl/shift_pkg.sv
// Shared constants and types for the shift-register sequencer.
package shift_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 3;

    // Select codes understood by the universal shift register
    localparam logic [SEL_W-1:0] SEL_HOLD = 3'd0;
    localparam logic [SEL_W-1:0] SEL_LOAD = 3'd1;
    localparam logic [SEL_W-1:0] SEL_SHL  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_SHR  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_ROL  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_ROR  = 3'd5;
    localparam logic [SEL_W-1:0] SEL_ASR  = 3'd6;
    localparam logic [SEL_W-1:0] SEL_CLR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    // HOLD and LOAD as a command op mean "just load the data"; no shift phase
    function automatic logic is_load_only(input logic [SEL_W-1:0] op);
        return (op == SEL_HOLD) || (op == SEL_LOAD);
    endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down-counter tracking the remaining shift cycles of a command.
// Saturates at zero so a stray decrement can never wrap.
module shift_down_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             is_zero_o,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load has priority over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags decoded from the registered count
    always_comb begin
        count_o   = cnt_q;
        is_zero_o = (cnt_q == '0);
        is_one_o  = (cnt_q == CNT_W'(1));
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a 4-bit universal shift register.
// One accepted command produces: one LOAD cycle, `count` cycles of the requested
// op, then a CAPTURE cycle where done pulses and the register value is returned.
// S and L are registered, decoded from the next state so they line up with the
// registered state.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [0:DATA_W-1] cmd_data,
    input  logic              abort,
    output logic [2:0]        S,
    output logic [0:DATA_W-1] L,
    input  logic [0:DATA_W-1] Q,
    output logic              busy,
    output logic              done,
    output logic [0:DATA_W-1] result
);

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [2:0]         s_q, s_d;
    logic [0:DATA_W-1]  l_q, l_d;
    logic [0:DATA_W-1]  result_q, result_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_value;
    logic               cnt_zero;
    logic               cnt_one;

    // Remaining-shift counter, loaded with the (possibly forced) count on accept
    shift_down_counter #(
        .CNT_W (CNT_W)
    ) u_remaining (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_value),
        .is_zero_o  (cnt_zero),
        .is_one_o   (cnt_one)
    );

    // Next-state, command latching and counter control
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        result_d     = result_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort is deliberately not looked at here
                if (cmd_valid) begin
                    op_d         = cmd_op;
                    cnt_load     = 1'b1;
                    cnt_load_val = is_load_only(cmd_op) ? '0 : cmd_count;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    cnt_load = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_zero) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    cnt_load = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_one) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                result_d = Q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register-side outputs for the coming cycle; LOAD is only entered on accept,
    // so cmd_data is the live command's data whenever it is selected
    always_comb begin
        s_d = SEL_HOLD;
        l_d = '0;
        case (state_d)
            LOAD: begin
                s_d = SEL_LOAD;
                l_d = cmd_data;
            end
            SHIFT: begin
                s_d = op_d;
            end
            default: begin
                s_d = SEL_HOLD;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            op_q     <= SEL_HOLD;
            s_q      <= SEL_HOLD;
            l_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            s_q      <= s_d;
            l_q      <= l_d;
            result_q <= result_d;
        end
    end

    // Status outputs; during CAPTURE the result is forwarded straight from Q so
    // it is already valid while done is high
    always_comb begin
        S         = s_q;
        L         = l_q;
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == CAPTURE);
        result    = (state_q == CAPTURE) ? Q : result_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shift register.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             Clock     = 1'b0;
    logic             Resetn    = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             abort     = 1'b0;
    logic [2:0]       cmd_op    = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [0:3]       cmd_data  = '0;
    logic             cmd_ready;
    logic             busy;
    logic             done;
    logic [2:0]       S;
    logic [0:3]       L;
    logic [0:3]       result;
    logic [0:3]       q_reg = '0;

    int         total = 0;
    int         bad   = 0;
    logic [0:3] prior = '0;

    shift_sequencer #(
        .CNT_W (CNT_W)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .S         (S),
        .L         (L),
        .Q         (q_reg),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 Clock = ~Clock;

    // One clock of the universal shift register (bit 0 = MSB)
    function automatic logic [0:3] step(input logic [2:0] sel, input logic [0:3] l,
                                        input logic [0:3] q);
        case (sel)
            SEL_HOLD: return q;
            SEL_LOAD: return l;
            SEL_SHL:  return {q[1:3], 1'b0};
            SEL_SHR:  return {1'b0, q[0:2]};
            SEL_ROL:  return {q[1:3], q[0]};
            SEL_ROR:  return {q[3], q[0:2]};
            SEL_ASR:  return {q[0], q[0:2]};
            default:  return 4'b0000;
        endcase
    endfunction

    always @(posedge Clock) q_reg <= step(S, L, q_reg);

    function automatic int eff_count(input logic [2:0] op, input int cnt);
        return ((op == SEL_LOAD) || (op == SEL_HOLD)) ? 0 : cnt;
    endfunction

    // Closed-form result of loading d then applying op n times
    function automatic logic [0:3] model_result(input logic [2:0] op, input logic [0:3] d,
                                                input int n);
        int v;
        int r;
        int s;
        v = int'(d);
        r = n % 4;
        case (op)
            SEL_SHL: v = (n >= 4) ? 0 : ((v << n) & 15);
            SEL_SHR: v = v >> n;
            SEL_ROL: v = ((v << r) | (v >> (4 - r))) & 15;
            SEL_ROR: v = ((v >> r) | (v << (4 - r))) & 15;
            SEL_ASR: begin
                s = (v >= 8) ? v - 16 : v;
                v = (s >>> n) & 15;
            end
            SEL_CLR: v = (n > 0) ? 0 : v;
            default: v = v;
        endcase
        return 4'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for ready, presents a command,
    // returns just after the accepting edge
    task automatic present(input logic [2:0] op, input int cnt, input logic [0:3] d,
                           input bit with_abort);
        int w;
        w = 0;
        while ((cmd_ready !== 1'b1) && (w < 40)) begin
            @(negedge Clock);
            w++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(cnt);
        cmd_data  = d;
        abort     = with_abort;
        @(posedge Clock);
    endtask

    // Follows one command cycle by cycle from its LOAD cycle (j=1)
    task automatic observe(input logic [2:0] op, input int cnt, input logic [0:3] d,
                           input int abort_j, input bit cap_abort, input bit hold_valid,
                           input logic [2:0] nop, input int ncnt, input logic [0:3] nd);
        int         eff;
        int         last;
        int         ph;   // 0 idle, 1 load, 2 shift, 3 capture
        logic [0:3] res;
        logic [0:3] exp_res;
        logic [2:0] exp_s;
        eff  = eff_count(op, cnt);
        res  = model_result(op, d, eff);
        last = (abort_j > 0) ? abort_j + 3 : eff + 3;
        for (int j = 1; j <= last; j++) begin
            @(negedge Clock);
            if ((abort_j > 0) && (j > abort_j)) ph = 0;
            else if (j == 1)                     ph = 1;
            else if (j <= eff + 1)               ph = 2;
            else if (j == eff + 2)               ph = 3;
            else                                 ph = 0;
            exp_s = (ph == 1) ? SEL_LOAD : (ph == 2) ? op : SEL_HOLD;
            if (ph == 3 || (ph == 0 && abort_j == 0)) exp_res = res;
            else                                      exp_res = prior;
            chk($sformatf("S j=%0d", j), S, exp_s);
            chk($sformatf("L j=%0d", j), L, (ph == 1) ? d : 4'b0000);
            chk($sformatf("done j=%0d", j), done, ph == 3);
            chk($sformatf("busy j=%0d", j), busy, ph != 0);
            chk($sformatf("ready j=%0d", j), cmd_ready, ph == 0);
            chk($sformatf("result j=%0d", j), result, exp_res);
            if (j == 1) begin
                abort = 1'b0;
                if (hold_valid) begin
                    cmd_op    = nop;
                    cmd_count = CNT_W'(ncnt);
                    cmd_data  = nd;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (j == abort_j)                   abort = 1'b1;
            if (abort_j > 0 && j == abort_j + 1) abort = 1'b0;
            if (cap_abort && j == eff + 2)      abort = 1'b1;
            if (cap_abort && j == eff + 3)      abort = 1'b0;
        end
        if (abort_j == 0) prior = res;
    endtask

    task automatic run(input logic [2:0] op, input int cnt, input logic [0:3] d,
                       input int abort_j, input bit cap_abort, input bit idle_abort);
        present(op, cnt, d, idle_abort);
        observe(op, cnt, d, abort_j, cap_abort, 1'b0, 3'd0, 0, 4'b0000);
    endtask

    initial begin
        logic [2:0] rop;
        int         rcnt;
        int         raj;
        logic [0:3] rdat;

        #1 Resetn = 1'b0;
        #11;
        chk("rst_S", S, SEL_HOLD);
        chk("rst_L", L, 0);
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Load-only: count forced to zero
        run(SEL_LOAD, 5, 4'b1011, 0, 1'b0, 1'b0);
        chk("load_only_const", result, 4'b1011);
        run(SEL_SHL, 1, 4'b1011, 0, 1'b0, 1'b0);
        chk("shl_const", result, 4'b0110);
        run(SEL_ROR, 2, 4'b1011, 0, 1'b0, 1'b0);
        chk("ror2_const", result, 4'b1110);
        run(SEL_ROR, 4, 4'b1011, 0, 1'b0, 1'b0);
        chk("ror4_const", result, 4'b1011);
        // Abort on the third SHIFT cycle
        run(SEL_SHR, 6, 4'b1011, 4, 1'b0, 1'b0);
        chk("abort_keeps_result", result, 4'b1011);
        // Maximum count, no wrap
        run(SEL_ROL, 15, 4'b1000, 0, 1'b0, 1'b0);
        run(SEL_CLR, 3, 4'b1111, 0, 1'b0, 1'b0);
        chk("clr_const", result, 4'b0000);
        run(SEL_ASR, 2, 4'b1001, 0, 1'b0, 1'b0);
        run(SEL_HOLD, 9, 4'b0101, 0, 1'b0, 1'b0);
        // abort alongside cmd_valid in IDLE, and abort during CAPTURE: both ignored
        run(SEL_SHR, 1, 4'b1100, 0, 1'b0, 1'b1);
        run(SEL_ROL, 2, 4'b0011, 0, 1'b1, 1'b0);

        // Back-to-back with cmd_valid held high
        present(SEL_SHL, 3, 4'b0011, 1'b0);
        observe(SEL_SHL, 3, 4'b0011, 0, 1'b0, 1'b1, SEL_ROR, 1, 4'b0110);
        chk("b2b_valid_held", cmd_valid, 1);
        @(posedge Clock);
        observe(SEL_ROR, 1, 4'b0110, 0, 1'b0, 1'b0, 3'd0, 0, 4'b0000);

        // Reset in the middle of a long SHIFT phase
        present(SEL_SHR, 10, 4'b1111, 1'b0);
        @(negedge Clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge Clock);
        chk("pre_rst_busy", busy, 1);
        #2 Resetn = 1'b0;
        #1;
        chk("midrst_S", S, SEL_HOLD);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        prior = '0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        @(negedge Clock);

        // Randomised commands against the model
        for (int i = 0; i < 30; i++) begin
            rop  = 3'($urandom_range(7, 0));
            rcnt = $urandom_range(15, 0);
            rdat = 4'($urandom_range(15, 0));
            raj  = 0;
            if ($urandom_range(3, 0) == 0) begin
                raj = $urandom_range(eff_count(rop, rcnt) + 1, 1);
            end
            run(rop, rcnt, rdat, raj, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
